// File: rtl/jt12_eg_sched.sv
// Envelope-generator slot scheduler.
// Walks the operator slots one per clk_en strobe, keeps the per-slot envelope
// state (attenuation, phase, SSG inversion, step-counter bit, previous key-on)
// and runs the global envelope counter, which steps once every DIV full sweeps.
module jt12_eg_sched #(
    parameter int SLOTS = 24,
    parameter int DIV   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        keyon_in,
    input  logic [9:0]  eg_next,
    input  logic [2:0]  state_next,
    input  logic        ssg_inv_next,
    input  logic        cnt_lsb,
    output logic [4:0]  slot,
    output logic        keyon_now,
    output logic        keyoff_now,
    output logic [2:0]  state_cur,
    output logic [9:0]  eg_cur,
    output logic        ssg_inv_cur,
    output logic        cnt_in,
    output logic [14:0] eg_cnt,
    output logic        eg_tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    // Per-slot storage, one entry per operator slot.
    logic [9:0] eg_mem  [SLOTS];
    logic [2:0] st_mem  [SLOTS];
    logic       ssg_mem [SLOTS];
    logic       cnt_mem [SLOTS];
    logic       kon_mem [SLOTS];

    logic [DW-1:0] div_cnt;
    logic          slot_last;
    logic          div_last;

    assign slot_last = (slot == 5'(SLOTS - 1));
    assign div_last  = (div_cnt == DW'(DIV - 1));

    // The first sweep after each counter step is the one where steps apply.
    assign eg_tick = (div_cnt == '0);

    // Read the current slot's entry and detect key edges against the stored bit.
    always_comb begin
        state_cur   = st_mem[slot];
        eg_cur      = eg_mem[slot];
        ssg_inv_cur = ssg_mem[slot];
        cnt_in      = cnt_mem[slot];
        keyon_now   = keyon_in & ~kon_mem[slot];
        keyoff_now  = ~keyon_in & kon_mem[slot];
    end

    // Slot pointer, sweep divider and global envelope counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= '0;
            div_cnt <= '0;
            eg_cnt  <= '0;
        end else if (clk_en) begin
            if (slot_last) begin
                slot <= '0;
                if (div_last) begin
                    div_cnt <= '0;
                    eg_cnt  <= eg_cnt + 15'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                slot <= slot + 5'd1;
            end
        end
    end

    // Write-back of the current slot only; reset restores every entry to silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                eg_mem[i]  <= 10'h3FF;
                st_mem[i]  <= 3'b000;
                ssg_mem[i] <= 1'b0;
                cnt_mem[i] <= 1'b0;
                kon_mem[i] <= 1'b0;
            end
        end else if (clk_en) begin
            eg_mem[slot]  <= eg_next;
            st_mem[slot]  <= state_next;
            ssg_mem[slot] <= ssg_inv_next;
            cnt_mem[slot] <= cnt_lsb;
            kon_mem[slot] <= keyon_in;
        end
    end

endmodule

// File: tb/tb_jt12_eg_sched.sv
// Self-checking bench for jt12_eg_sched: reset state, counter timing,
// key edges and write-back (table + scoreboard), stall, reset mid-sweep,
// and envelope counter wrap.
module tb_jt12_eg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        keyon_in;
    logic [9:0]  eg_next;
    logic [2:0]  state_next;
    logic        ssg_inv_next;
    logic        cnt_lsb;
    logic [4:0]  slot;
    logic        keyon_now;
    logic        keyoff_now;
    logic [2:0]  state_cur;
    logic [9:0]  eg_cur;
    logic        ssg_inv_cur;
    logic        cnt_in;
    logic [14:0] eg_cnt;
    logic        eg_tick;

    jt12_eg_sched #(.SLOTS(24), .DIV(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .keyon_in     (keyon_in),
        .eg_next      (eg_next),
        .state_next   (state_next),
        .ssg_inv_next (ssg_inv_next),
        .cnt_lsb      (cnt_lsb),
        .slot         (slot),
        .keyon_now    (keyon_now),
        .keyoff_now   (keyoff_now),
        .state_cur    (state_cur),
        .eg_cur       (eg_cur),
        .ssg_inv_cur  (ssg_inv_cur),
        .cnt_in       (cnt_in),
        .eg_cnt       (eg_cnt),
        .eg_tick      (eg_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kon;
        logic [9:0] egn;
        logic [2:0] stn;
        logic       ssg;
        logic       cnt;
        logic [4:0] x_slot;
        logic       x_kon;
        logic       x_koff;
        logic [9:0] x_eg;
        logic [2:0] x_st;
        logic       x_ssg;
        logic       x_cnt;
        logic       x_tick;
    } vec_t;

    typedef struct {
        logic [4:0] s;
        logic [9:0] eg;
        logic [2:0] st;
        logic       ssg;
        logic       cnt;
    } sb_t;

    vec_t tbl [72];
    sb_t  sbq [$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic defaults();
        keyon_in     = 1'b0;
        eg_next      = 10'h3FF;
        state_next   = 3'b000;
        ssg_inv_next = 1'b0;
        cnt_lsb      = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clk_en = 1'b0;
        step();
        rst    = 1'b0;
    endtask

    initial begin
        sb_t e;
        int  sw, s;

        // Table: three sweeps from reset. Key held at slot 5 for two sweeps,
        // slot 3 written 0x155/001 in sweep 0, slot 9 written with flags in sweep 1,
        // slot 17 gets its counter bit in sweep 0.
        for (int k = 0; k < 72; k++) begin
            sw = k / 24;
            s  = k % 24;
            tbl[k].kon    = (s == 5) && (sw < 2);
            tbl[k].egn    = (sw == 0 && s == 3) ? 10'h155 : (sw == 1 && s == 9) ? 10'h2A0 : 10'h3FF;
            tbl[k].stn    = (sw == 0 && s == 3) ? 3'b001  : (sw == 1 && s == 9) ? 3'b101  : 3'b000;
            tbl[k].ssg    = (sw == 1 && s == 9);
            tbl[k].cnt    = (sw == 0 && s == 17);
            tbl[k].x_slot = 5'(s);
            tbl[k].x_kon  = (s == 5) && (sw == 0);
            tbl[k].x_koff = (s == 5) && (sw == 2);
            tbl[k].x_eg   = (sw == 1 && s == 3) ? 10'h155 : (sw == 2 && s == 9) ? 10'h2A0 : 10'h3FF;
            tbl[k].x_st   = (sw == 1 && s == 3) ? 3'b001  : (sw == 2 && s == 9) ? 3'b101  : 3'b000;
            tbl[k].x_ssg  = (sw == 2 && s == 9);
            tbl[k].x_cnt  = (sw == 1 && s == 17);
            tbl[k].x_tick = (sw == 0);
        end

        defaults();
        rst    = 1'b1;
        clk_en = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_cnt", 32'(eg_cnt), 32'd0);
        chk("rst_eg", 32'(eg_cur), 32'h3FF);
        chk("rst_state", 32'(state_cur), 32'd0);
        chk("rst_tick", 32'(eg_tick), 32'd1);
        chk("rst_koff", 32'(keyoff_now), 32'd0);
        keyon_in = 1'b1;
        #1;
        chk("rst_kon_hi", 32'(keyon_now), 32'd1);
        keyon_in = 1'b0;
        #1;
        chk("rst_kon_lo", 32'(keyon_now), 32'd0);

        // Counter timing over four sweeps
        clk_en = 1'b1;
        for (int p = 0; p < 96; p++) begin
            chk("tm_slot", 32'(slot), 32'(p % 24));
            chk("tm_tick", 32'(eg_tick), (p < 24 || p >= 72) ? 32'd1 : 32'd0);
            chk("tm_cnt", 32'(eg_cnt), (p >= 72) ? 32'd1 : 32'd0);
            step();
        end
        clk_en = 1'b0;

        // Table-driven sweeps with a write-back scoreboard
        do_reset();
        clk_en = 1'b1;
        for (int k = 0; k < 72; k++) begin
            keyon_in     = tbl[k].kon;
            eg_next      = tbl[k].egn;
            state_next   = tbl[k].stn;
            ssg_inv_next = tbl[k].ssg;
            cnt_lsb      = tbl[k].cnt;
            #1;
            chk("tb_slot", 32'(slot), 32'(tbl[k].x_slot));
            chk("tb_kon", 32'(keyon_now), 32'(tbl[k].x_kon));
            chk("tb_koff", 32'(keyoff_now), 32'(tbl[k].x_koff));
            chk("tb_eg", 32'(eg_cur), 32'(tbl[k].x_eg));
            chk("tb_state", 32'(state_cur), 32'(tbl[k].x_st));
            chk("tb_ssg", 32'(ssg_inv_cur), 32'(tbl[k].x_ssg));
            chk("tb_cnt", 32'(cnt_in), 32'(tbl[k].x_cnt));
            chk("tb_tick", 32'(eg_tick), 32'(tbl[k].x_tick));
            if (k >= 24) begin
                e = sbq.pop_front();
                chk("sb_slot", 32'(slot), 32'(e.s));
                chk("sb_eg", 32'(eg_cur), 32'(e.eg));
                chk("sb_state", 32'(state_cur), 32'(e.st));
                chk("sb_ssg", 32'(ssg_inv_cur), 32'(e.ssg));
                chk("sb_cnt", 32'(cnt_in), 32'(e.cnt));
            end
            sbq.push_back('{s: tbl[k].x_slot, eg: tbl[k].egn, st: tbl[k].stn,
                            ssg: tbl[k].ssg, cnt: tbl[k].cnt});
            step();
        end
        sbq.delete();
        defaults();
        chk("tb_end_cnt", 32'(eg_cnt), 32'd1);

        // Stall at slot 10 with noisy datapath inputs
        for (int p = 0; p < 10; p++) step();
        clk_en = 1'b0;
        for (int c = 0; c < 50; c++) begin
            eg_next      = 10'($urandom);
            state_next   = 3'($urandom);
            ssg_inv_next = 1'($urandom);
            cnt_lsb      = 1'($urandom);
            step();
            chk("st_slot", 32'(slot), 32'd10);
            chk("st_cnt", 32'(eg_cnt), 32'd1);
            chk("st_eg", 32'(eg_cur), 32'h3FF);
            chk("st_state", 32'(state_cur), 32'd0);
            chk("st_tick", 32'(eg_tick), 32'd1);
            chk("st_koff", 32'(keyoff_now), 32'd0);
        end

        // Dirty most slots, then reset mid-sweep at slot 7 with clk_en high
        defaults();
        eg_next    = 10'h0F0;
        state_next = 3'b010;
        clk_en     = 1'b1;
        for (int p = 0; p < 21; p++) step();
        chk("pre_rst_slot", 32'(slot), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        defaults();
        chk("mrst_slot", 32'(slot), 32'd0);
        chk("mrst_cnt", 32'(eg_cnt), 32'd0);
        chk("mrst_tick", 32'(eg_tick), 32'd1);
        for (int p = 0; p < 24; p++) begin
            chk("mrst_eg", 32'(eg_cur), 32'h3FF);
            chk("mrst_state", 32'(state_cur), 32'd0);
            step();
        end
        clk_en = 1'b0;

        // Envelope counter wrap
        do_reset();
        force dut.eg_cnt = 15'h7FFF;
        #1;
        release dut.eg_cnt;
        #1;
        chk("wr_pre", 32'(eg_cnt), 32'h7FFF);
        clk_en = 1'b1;
        for (int p = 0; p < 71; p++) step();
        chk("wr_hold", 32'(eg_cnt), 32'h7FFF);
        step();
        clk_en = 1'b0;
        chk("wr_cnt", 32'(eg_cnt), 32'h0000);
        chk("wr_slot", 32'(slot), 32'd0);
        chk("wr_tick", 32'(eg_tick), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/jt12_eg_sched.md
JT12_EG_SCHED -- requirements
Module: jt12_eg_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 24, number of operator slots (6 channels x 4 operators).
REQ-002 SHALL have parameter DIV, default 3, number of full slot sweeps per envelope counter step.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clk_en  input  1  slot-advance strobe; all state holds while low.
REQ-006 SHALL have port keyon_in  input  1  key-on register bit for the current slot.
REQ-007 SHALL have port eg_next  input  10  envelope attenuation computed by the datapath for the current slot.
REQ-008 SHALL have port state_next  input  3  next envelope state from the control stage.
REQ-009 SHALL have port ssg_inv_next  input  1  next SSG inversion flag.
REQ-010 SHALL have port cnt_lsb  input  1  step-stage counter bit to store for the current slot.
REQ-011 SHALL have port slot  output  5  current slot index.
REQ-012 SHALL have port keyon_now  output  1  key-on edge for the current slot.
REQ-013 SHALL have port keyoff_now  output  1  key-off edge for the current slot.
REQ-014 SHALL have port state_cur  output  3  stored envelope state of the current slot.
REQ-015 SHALL have port eg_cur  output  10  stored attenuation of the current slot.
REQ-016 SHALL have port ssg_inv_cur  output  1  stored SSG inversion of the current slot.
REQ-017 SHALL have port cnt_in  output  1  stored step-stage counter bit of the current slot.
REQ-018 SHALL have port eg_cnt  output  15  global envelope counter.
REQ-019 SHALL have port eg_tick  output  1  high during every sweep in which envelope steps apply.

Function
REQ-020 SHALL hold per-slot storage of SLOTS entries: eg (10b), state (3b), ssg_inv (1b), cnt (1b), keyon_prev (1b).
REQ-021 SHALL drive state_cur, eg_cur, ssg_inv_cur and cnt_in combinationally from the entry indexed by slot.
REQ-022 SHALL compute keyon_now = keyon_in AND NOT keyon_prev[slot], and keyoff_now = NOT keyon_in AND keyon_prev[slot], combinationally.
REQ-023 SHALL, on a clk_en cycle, write eg_next, state_next, ssg_inv_next, cnt_lsb and keyon_in into entry [slot]; write-back takes effect on the following edge (latency 1 clk).
REQ-024 SHALL, on a clk_en cycle, advance slot by 1, wrapping SLOTS-1 -> 0.
REQ-025 SHALL keep a sweep divider counting 0..DIV-1 that increments when slot wraps, wrapping DIV-1 -> 0.
REQ-026 SHALL increment eg_cnt by 1 on the same edge on which the divider wraps DIV-1 -> 0; eg_cnt wraps 0x7FFF -> 0x0000.
REQ-027 SHALL drive eg_tick = (divider == 0), so eg_tick spans exactly one full sweep following each eg_cnt update.
REQ-028 SHALL leave slot, divider, eg_cnt and all storage unchanged on cycles with clk_en low, regardless of other inputs.
REQ-029 SHALL write entries only for the slot currently indexed; no other entry is modified in that cycle.
REQ-030 SHALL pass state_next and eg_next through without validation; no values are clamped or illegal.

Reset
REQ-031 SHALL, on rst high at a clock edge, set slot=0, divider=0, eg_cnt=0.
REQ-032 SHALL, on reset, set every entry to eg=0x3FF, state=3'b000 (release), ssg_inv=0, cnt=0, keyon_prev=0.
REQ-033 SHALL give rst priority over clk_en; a mid-sweep reset discards that cycle's write-back.
REQ-034 SHALL, after reset, output eg_cur=0x3FF, state_cur=0, keyon_now=keyon_in, keyoff_now=0 and eg_tick=1.

Verification
REQ-035 SHALL verify reset: assert rst with clk_en=1 at slot 7 -> next cycle slot=0, eg_cnt=0, eg_cur=0x3FF in all 24 slots.
REQ-036 SHALL verify counter timing: run 72 clk_en pulses -> eg_cnt=1 and slot=0; eg_tick=0 for pulses 24-71 and 1 for pulses 0-23 and 72-95.
REQ-037 SHALL verify the key edge: keyon_in=1 at slot 5 only -> keyon_now=1 on the first visit to slot 5, 0 on the second, and keyoff_now=1 once after keyon_in returns to 0.
REQ-038 SHALL verify write-back: eg_next=0x155 and state_next=3'b001 at slot 3 -> one sweep later eg_cur=0x155 and state_cur=001 at slot 3, while the other slots stay 0x3FF.
REQ-039 SHALL verify the stall: clk_en=0 for 50 cycles at slot 10 -> slot, eg_cnt and all outputs stay constant.
REQ-040 SHALL verify counter wrap: force eg_cnt to 0x7FFF and run one divider wrap -> eg_cnt=0x0000.
